ctrl_resolve_unit: RTL
======================

// Module: ctrl_resolve_unit
// PURPOSE
//  Consumer end of the control-ALU result interface. Registers each resolved control
//  instruction (pc, nextPC, direction, flags). On a mispredict it raises a one-cycle
//  fetch recovery with the corrected PC, then squashes younger results for a fixed window.
//  Queues predictor-update records and drains them to the BTB/BPB over valid/ready.
//  Sits between the execute-stage control ALU and the fetch/branch-prediction front end.
// PARAMETERS
//  SIZE_PC        32  PC / target width
//  DEPTH           4  update-queue entries (power of 2, >=2)
//  SQUASH_CYCLES   2  cycles of result suppression after a recovery pulse (>=1)
// PORTS
//  clk            in   1        rising-edge clock
//  reset          in   1        asynchronous, active-low reset
//  valid_i        in   1        control-ALU result valid this cycle
//  pc_i           in   SIZE_PC  PC of resolved instruction
//  nextPC_i       in   SIZE_PC  resolved next PC
//  direction_i    in   1        resolved taken/not-taken
//  flags_i        in   8        [7]ctrl [5]cond-update [4]link [2]executed [0]mispredict
//  flush_i        in   1        external pipeline flush (older exception/recovery)
//  recover_o      out  1        one-cycle fetch redirect pulse
//  recoverPC_o    out  SIZE_PC  redirect target, valid when recover_o=1
//  updValid_o     out  1        update record at queue head
//  updReady_i     in   1        predictor accepts head record
//  updPC_o        out  SIZE_PC  head: branch PC
//  updTarget_o    out  SIZE_PC  head: resolved nextPC
//  updDir_o       out  1        head: direction
//  updCond_o      out  1        head: flags[5] (direction-predictor update needed)
//  full_o         out  1        queue holds DEPTH entries
//  overflow_o     out  1        sticky: a result was dropped because the queue was full
//  brCount_o      out  32       saturating count of accepted results
//  mispCount_o    out  32       saturating count of recoveries issued
// BEHAVIOUR
//  - Reset (async, reset=0): all outputs 0, queue empty, FSM=IDLE, counters 0, sticky clear.
//  - Accept: valid_i & flags_i[7] & flags_i[2] & state==IDLE & ~flush_i. Otherwise ignored.
//  - Enqueue on accept: {pc_i,nextPC_i,direction_i,flags_i[5]} written at tail. Visible on
//    upd* the next cycle. No same-cycle bypass.
//  - Dequeue: updValid_o & updReady_i pops head. upd* holds stable while updReady_i=0.
//  - Full: accept while full with no dequeue in that cycle drops the record and sets
//    overflow_o. overflow_o clears only on reset.
//  - Full with a dequeue in the same cycle: the enqueue succeeds and the count is unchanged.
//  - Pointers: log2(DEPTH) bits, wrap modulo DEPTH. Occupancy counter is log2(DEPTH)+1 bits.
//  - Recovery: accept with flags_i[0]=1 registers recover_o=1 and recoverPC_o=nextPC_i
//    for exactly the next cycle. That record is still enqueued (subject to full).
//  - FSM:
//      IDLE    -> SQUASH on an accepted mispredict; load squash counter with SQUASH_CYCLES.
//      SQUASH  decrements each cycle; all valid_i ignored; -> IDLE when the counter reaches 0.
//  - flush_i=1:
//      clears queue pointers and occupancy; FSM -> IDLE; squash counter cleared.
//      Suppresses a same-cycle accept and recovery. Does not cancel a recover_o already
//      registered. Counters and overflow are unaffected.
//  - Counters: brCount_o +1 per accept; mispCount_o +1 per recovery. Both saturate at
//    32'hFFFF_FFFF.
//  - Latency: result -> recover_o 1 cycle; result -> updValid_o 1 cycle (queue empty).
// TESTING
//  1. Reset mid-stream (queue holding 3 entries, FSM=SQUASH) -> next cycle all outputs 0,
//     updValid_o=0, FSM IDLE.
//  2. Correct BEQ, pc=0x400, nextPC=0x408, flags=8'hA4 -> updValid_o=1 next cycle with
//     updPC_o=0x400, updTarget_o=0x408, updCond_o=1; recover_o stays 0.
//  3. BNE mispredict, nextPC=0x500, flags=8'hA5, followed by 2 valid results ->
//     recover_o=1 for exactly one cycle with recoverPC_o=0x500; both following results
//     dropped (SQUASH_CYCLES=2); mispCount_o=1.
//  4. updReady_i=0, 5 accepts (DEPTH=4) -> full_o=1 after 4; 5th dropped; overflow_o=1;
//     brCount_o=5.
//  5. Queue full, accept together with updReady_i=1 -> pop and push in the same cycle;
//     full_o stays 1; order preserved.
//  6. flush_i together with an accepted mispredict -> no recover_o, queue empty, FSM IDLE.

Source files
------------

// File: rtl/ctrl_resolve_unit.sv
// rtl/ctrl_resolve_unit.sv - control-ALU result consumer: recovery pulse, squash window, predictor update queue
module ctrl_resolve_unit #(
    parameter int SIZE_PC       = 32,
    parameter int DEPTH         = 4,
    parameter int SQUASH_CYCLES = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               valid_i,
    input  logic [SIZE_PC-1:0] pc_i,
    input  logic [SIZE_PC-1:0] nextPC_i,
    input  logic               direction_i,
    input  logic [7:0]         flags_i,
    input  logic               flush_i,
    output logic               recover_o,
    output logic [SIZE_PC-1:0] recoverPC_o,
    output logic               updValid_o,
    input  logic               updReady_i,
    output logic [SIZE_PC-1:0] updPC_o,
    output logic [SIZE_PC-1:0] updTarget_o,
    output logic               updDir_o,
    output logic               updCond_o,
    output logic               full_o,
    output logic               overflow_o,
    output logic [31:0]        brCount_o,
    output logic [31:0]        mispCount_o
);

    localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW  = AW + 1;
    localparam int SCW = $clog2(SQUASH_CYCLES + 1);
    localparam logic [CW-1:0]  DEPTH_C  = CW'(DEPTH);
    localparam logic [SCW-1:0] SQUASH_C = SCW'(SQUASH_CYCLES);

    typedef enum logic {IDLE, SQUASH} state_t;

    state_t         state, state_next;
    logic [SCW-1:0] squash_cnt, squash_cnt_next;

    logic [SIZE_PC-1:0] pc_mem  [DEPTH];
    logic [SIZE_PC-1:0] tgt_mem [DEPTH];
    logic               dir_mem [DEPTH];
    logic               cond_mem[DEPTH];

    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;

    logic accept, mispredict, q_full, q_nonempty, push, pop;

    assign accept     = valid_i & flags_i[7] & flags_i[2] & (state == IDLE) & ~flush_i;
    assign mispredict = accept & flags_i[0];
    assign q_full     = (count == DEPTH_C);
    assign q_nonempty = (count != '0);
    assign pop        = q_nonempty & updReady_i;
    // A full queue still takes a push when the head leaves in the same cycle.
    assign push       = accept & (~q_full | pop);

    // Next-state logic: squash window is entered on an accepted mispredict, flush forces idle.
    always_comb begin
        state_next      = state;
        squash_cnt_next = squash_cnt;
        if (flush_i) begin
            state_next      = IDLE;
            squash_cnt_next = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (mispredict) begin
                        state_next      = SQUASH;
                        squash_cnt_next = SQUASH_C;
                    end
                end
                SQUASH: begin
                    squash_cnt_next = squash_cnt - SCW'(1);
                    if (squash_cnt <= SCW'(1)) begin
                        state_next      = IDLE;
                        squash_cnt_next = '0;
                    end
                end
                default: begin
                    state_next      = IDLE;
                    squash_cnt_next = '0;
                end
            endcase
        end
    end

    // State register for the squash FSM.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            squash_cnt <= '0;
        end else begin
            state      <= state_next;
            squash_cnt <= squash_cnt_next;
        end
    end

    // Recovery pulse: one cycle after the accepted mispredict, target held until the next one.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            recover_o   <= 1'b0;
            recoverPC_o <= '0;
        end else begin
            recover_o <= mispredict;
            if (mispredict) begin
                recoverPC_o <= nextPC_i;
            end
        end
    end

    // Queue storage; contents need no reset because outputs are gated by occupancy.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]   <= pc_i;
            tgt_mem[wr_ptr]  <= nextPC_i;
            dir_mem[wr_ptr]  <= direction_i;
            cond_mem[wr_ptr] <= flags_i[5];
        end
    end

    // Queue pointers and occupancy; flush discards everything in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Sticky overflow and saturating statistics; flush leaves these alone.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow_o  <= 1'b0;
            brCount_o   <= '0;
            mispCount_o <= '0;
        end else begin
            if (accept && q_full && !pop) begin
                overflow_o <= 1'b1;
            end
            if (accept && brCount_o != 32'hFFFF_FFFF) begin
                brCount_o <= brCount_o + 32'd1;
            end
            if (mispredict && mispCount_o != 32'hFFFF_FFFF) begin
                mispCount_o <= mispCount_o + 32'd1;
            end
        end
    end

    assign updValid_o  = q_nonempty;
    assign updPC_o     = q_nonempty ? pc_mem[rd_ptr]   : '0;
    assign updTarget_o = q_nonempty ? tgt_mem[rd_ptr]  : '0;
    assign updDir_o    = q_nonempty & dir_mem[rd_ptr];
    assign updCond_o   = q_nonempty & cond_mem[rd_ptr];
    assign full_o      = q_full;

endmodule
